// File: rtl/fifo_sync_level.sv
// Single-clock first-word-fall-through FIFO using all 2^log_depth entries, with
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module fifo_sync_level #(
   parameter int width     = 20,
   parameter int log_depth = 3,
   parameter int af_thresh = (1 << log_depth) - 2,
   parameter int ae_thresh = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_err,
   input  logic                 val_wr,
   input  logic [width-1:0]     data_wr,
   input  logic                 val_rd,
   output logic [width-1:0]     data_rd,
   output logic [log_depth:0]   count,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_empty,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = 1 << log_depth;
   localparam logic [log_depth:0] FULL_CNT = {1'b1, {log_depth{1'b0}}};
   localparam logic [log_depth:0] AF_CNT   = af_thresh[log_depth:0];
   localparam logic [log_depth:0] AE_CNT   = ae_thresh[log_depth:0];

   logic [width-1:0]     mem [0:DEPTH-1];
   logic [log_depth-1:0] wr_ptr, rd_ptr;
   logic                 rd_acc, wr_acc;

   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign almost_empty = (count <= AE_CNT);
   assign almost_full  = (count >= AF_CNT);

   // A full FIFO still takes a write when the head is popped in the same cycle.
   assign rd_acc = val_rd & ~empty;
   assign wr_acc = val_wr & (~full | rd_acc);

   assign data_rd = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr] <= data_wr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A fresh error wins over a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (val_wr && !wr_acc)  overflow <= 1'b1;
         else if (clr_err)       overflow <= 1'b0;
         if (val_rd && !rd_acc)  underflow <= 1'b1;
         else if (clr_err)       underflow <= 1'b0;
      end
   end

endmodule

// File: doc/fifo_sync_level.md
Name: fifo_sync_level

Overview:
- Single-clock, first-word-fall-through FIFO that replaces the non-synchronising resync FIFO wherever the producer and consumer share one clock. Typical use is the GTX channel model's fabric-side buffering.
- Uses all 2^log_depth entries; the old scheme lost one slot.
- Adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.

Parameters:
- width, 20, data word width in bits.
- log_depth, 3, log2 of the entry count; depth = 1 << log_depth, range 1..10.
- af_thresh, depth-2, almost_full asserts when count >= af_thresh; legal range 1..depth.
- ae_thresh, 1, almost_empty asserts when count <= ae_thresh; legal range 0..depth-1.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_err  in  1  synchronous clear of the overflow and underflow flags.
- val_wr  in  1  write request.
- data_wr  in  width  write data.
- val_rd  in  1  read request; pops the word currently shown on data_rd.
- data_rd  out  width  head-of-FIFO word (FWFT); only valid while empty is 0.
- count  out  log_depth+1  number of stored words, 0..depth.
- empty  out  1  count == 0.
- full  out  1  count == depth.
- almost_empty  out  1  count <= ae_thresh.
- almost_full  out  1  count >= af_thresh.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- State consists of:
  - wr_ptr and rd_ptr, each log_depth bits, wrapping modulo depth;
  - count, log_depth+1 bits;
  - the memory array;
  - the two sticky flags.
- All flags are decoded combinationally from the registered count. There is no separate state machine; pointers, count and flags together form the state.
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - The memory array is not reset; data_rd is don't-care while empty=1.
  - rst overrides every other input in that cycle, including clr_err and any val_wr/val_rd. A mid-stream reset discards all contents.
- Read acceptance: rd_acc = val_rd & ~empty.
- Write acceptance: wr_acc = val_wr & (~full | rd_acc). When full, a write is accepted in the same cycle as an accepted read.
- wr_acc: mem[wr_ptr] <= data_wr and wr_ptr increments, wrapping from depth-1 to 0.
- rd_acc: rd_ptr increments, wrapping the same way.
- count update:
  - +1 when wr_acc & ~rd_acc;
  - -1 when rd_acc & ~wr_acc;
  - unchanged when both or neither are accepted.
- data_rd = mem[rd_ptr], combinational. Latency from write to visibility:
  - A word written into an empty FIFO appears on data_rd the cycle after the write edge, with empty=0 in that same cycle.
  - Write-to-read latency is therefore 1 clock.
- Simultaneous read and write while empty: the read is rejected and underflow sets; the write is accepted and count becomes 1.
- Simultaneous read and write while full: both are accepted; count stays at depth and no overflow is flagged.
- Error flags:
  - overflow sets on val_wr & ~wr_acc.
  - underflow sets on val_rd & ~rd_acc.
  - Both hold until a clock edge with rst=1 or clr_err=1.
  - If clr_err coincides with a new error event, the set wins and the flag stays 1.
- Rejected accesses change no pointer, no count and no memory entry.

Test Plan:
- Fill and drain (width=20, log_depth=3):
  - Write 8 words 0x00001..0x00008 back-to-back, then expect full=1, count=8, almost_full=1.
  - Read 8 words; expect data_rd to be 0x00001..0x00008 in order, then empty=1, count=0, overflow=0, underflow=0.
- Overflow:
  - From full, assert val_wr with 0xABCDE and val_rd=0; expect overflow=1 from the next cycle, count=8, and the contents unchanged.
  - Pulse clr_err; expect overflow=0.
- Underflow and empty simultaneous access:
  - From empty, assert val_rd alone; expect underflow=1 and count=0.
  - Then assert val_rd and val_wr together with 0x12345; expect count=1 and data_rd=0x12345 the next cycle.
- Full simultaneous access:
  - From full, perform 20 cycles with val_wr=val_rd=1 and incrementing data; expect count=8 throughout.
  - Expect the read sequence to continue in order through several pointer wraps, with overflow=0.
- Thresholds: set af_thresh=6 and ae_thresh=2; step count 0..8..0 and expect almost_full=1 exactly for count 6..8, and almost_empty=1 exactly for count 0..2.
- Reset mid-operation:
  - With count=5 and val_wr=val_rd=1, assert rst for one cycle; the next cycle expect count=0, empty=1, overflow=0, underflow=0.
  - Then write 0x00777; expect data_rd=0x00777 one cycle later.
